// File: rtl/sap1_pkg.sv
// -----------------------------------------------------------------------------
// sap1_pkg
// Shared constants for the SAP-1 controller, datapath and ALU bench.
//   - Opcode encodings (upper nibble of the instruction register)
//   - One-hot T-state codes (bit0 = T1)
//   - Control-word bit indices, so every block agrees on strobe positions
//   - Controller run/halt mode enum
// -----------------------------------------------------------------------------
package sap1_pkg;

    // Opcode field width in the instruction register
    localparam int OPCODE_W = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OPCODE_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OPCODE_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OPCODE_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OPCODE_W-1:0] OP_HLT = 4'b1111;

    // One-hot T-state ring, bit0 = T1; all-zero marks the halted machine
    localparam int T_W = 6;

    localparam logic [T_W-1:0] T1     = 6'b000001;
    localparam logic [T_W-1:0] T2     = 6'b000010;
    localparam logic [T_W-1:0] T3     = 6'b000100;
    localparam logic [T_W-1:0] T4     = 6'b001000;
    localparam logic [T_W-1:0] T5     = 6'b010000;
    localparam logic [T_W-1:0] T6     = 6'b100000;
    localparam logic [T_W-1:0] T_NONE = 6'b000000;

    // Control-word bit positions
    localparam int CW_PC_INC     = 0;
    localparam int CW_PC_OUT     = 1;
    localparam int CW_MAR_LOAD   = 2;
    localparam int CW_RAM_OUT    = 3;
    localparam int CW_IR_LOAD    = 4;
    localparam int CW_IR_OUT     = 5;
    localparam int CW_A_LOAD     = 6;
    localparam int CW_A_OUT      = 7;
    localparam int CW_B_LOAD     = 8;
    localparam int CW_OP         = 9;
    localparam int CW_ALU_OUT_EN = 10;
    localparam int CW_OUT_LOAD   = 11;
    localparam int CW_W          = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Controller mode: stepping the ring, or parked after HLT
    typedef enum logic {
        MODE_RUN  = 1'b0,
        MODE_HALT = 1'b1
    } mode_t;

endpackage : sap1_pkg

// File: rtl/ring_counter.sv
// -----------------------------------------------------------------------------
// ring_counter
// Six-state one-hot T-cycle sequencer for the SAP-1 controller.
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, returns the ring to T1
//   hold     in   zeroes the ring (used to park the machine in HALT)
//   t_state  out  one-hot T1..T6, bit0 = T1; all-zero while held
// -----------------------------------------------------------------------------
module ring_counter
    import sap1_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           hold,
    output logic [T_W-1:0] t_state
);

    // Rotate left one position per clock. Once zeroed by hold, the ring
    // stays zero until reset reloads T1.
    always_ff @(posedge clk) begin
        if (rst) begin
            t_state <= T1;
        end else if (hold) begin
            t_state <= T_NONE;
        end else begin
            t_state <= {t_state[T_W-2:0], t_state[T_W-1]};
        end
    end

endmodule : ring_counter

// File: rtl/sap1_controller.sv
// -----------------------------------------------------------------------------
// sap1_controller
// Controller-sequencer for the SAP-1 datapath. Steps a six-state T ring,
// decodes the IR opcode and drives every load/enable strobe and the ALU
// add/subtract select.
// Parameters:
//   OPW         opcode width (upper nibble of IR)
// Ports:
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   opcode      in   IR upper nibble, valid from T4 onward
//   pc_inc      out  Cp  program counter increment
//   pc_out      out  Ep  PC drives bus
//   mar_load    out  Lm  MAR loads from bus
//   ram_out     out  CE  RAM drives bus
//   ir_load     out  Li  IR loads from bus
//   ir_out      out  Ei  IR lower nibble drives bus
//   a_load      out  La  accumulator loads
//   a_out       out  Ea  accumulator drives bus
//   b_load      out  Lb  B register loads
//   op          out  Su  ALU select, 0 add / 1 subtract
//   alu_out_en  out  Eu  ALU result drives bus
//   out_load    out  Lo  output register loads
//   halted      out  high once HLT has executed
//   t_state     out  one-hot T1..T6 (bit0 = T1), zero when halted
// -----------------------------------------------------------------------------
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPW = OPCODE_W
)
(
    input  logic           clk,
    input  logic           rst,
    input  logic [OPW-1:0] opcode,
    output logic           pc_inc,
    output logic           pc_out,
    output logic           mar_load,
    output logic           ram_out,
    output logic           ir_load,
    output logic           ir_out,
    output logic           a_load,
    output logic           a_out,
    output logic           b_load,
    output logic           op,
    output logic           alu_out_en,
    output logic           out_load,
    output logic           halted,
    output logic [T_W-1:0] t_state
);

    mode_t           mode_q;
    mode_t           mode_d;
    logic [T_W-1:0]  ring;
    logic [OPW-1:0]  cap_opcode;
    logic            in_t4;
    logic            hlt_now;
    logic            ring_hold;
    ctrl_word_t      cw;

    function automatic logic is_op(input logic [OPW-1:0] code,
                                   input logic [OPCODE_W-1:0] ref_op);
        return code == OPW'(ref_op);
    endfunction

    assign in_t4     = (mode_q == MODE_RUN) && (ring == T4);
    assign hlt_now   = in_t4 && is_op(opcode, OP_HLT);
    assign ring_hold = hlt_now || (mode_q == MODE_HALT);

    ring_counter u_ring (
        .clk     (clk),
        .rst     (rst),
        .hold    (ring_hold),
        .t_state (ring)
    );

    // Mode register: HALT is entered on the edge leaving T4 of a HLT and is
    // only left through reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_RUN;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        if ((mode_q == MODE_RUN) && hlt_now) begin
            mode_d = MODE_HALT;
        end
    end

    // The opcode is sampled on the T4->T5 edge so T5/T6 decode is immune to
    // later changes on the IR nibble.
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_opcode <= '0;
        end else if (in_t4) begin
            cap_opcode <= opcode;
        end
    end

    // Control-word decode. T4 looks at the live opcode; T5/T6 use the
    // captured copy, so op is a pure function of registered state there and
    // can only move on a clock edge. Everything is forced off during reset
    // and while halted.
    always_comb begin
        cw = '0;
        if (!rst && (mode_q == MODE_RUN)) begin
            unique case (ring)
                T1: begin
                    cw[CW_PC_OUT]   = 1'b1;
                    cw[CW_MAR_LOAD] = 1'b1;
                end
                T2: begin
                    cw[CW_PC_INC] = 1'b1;
                end
                T3: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_IR_LOAD] = 1'b1;
                end
                T4: begin
                    if (is_op(opcode, OP_LDA) || is_op(opcode, OP_ADD) ||
                        is_op(opcode, OP_SUB)) begin
                        cw[CW_IR_OUT]   = 1'b1;
                        cw[CW_MAR_LOAD] = 1'b1;
                    end else if (is_op(opcode, OP_OUT)) begin
                        cw[CW_A_OUT]    = 1'b1;
                        cw[CW_OUT_LOAD] = 1'b1;
                    end
                end
                T5: begin
                    if (is_op(cap_opcode, OP_LDA)) begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_LOAD]  = 1'b1;
                    end else if (is_op(cap_opcode, OP_ADD) ||
                                 is_op(cap_opcode, OP_SUB)) begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_LOAD]  = 1'b1;
                        cw[CW_OP]      = is_op(cap_opcode, OP_SUB);
                    end
                end
                T6: begin
                    if (is_op(cap_opcode, OP_ADD) || is_op(cap_opcode, OP_SUB)) begin
                        cw[CW_ALU_OUT_EN] = 1'b1;
                        cw[CW_A_LOAD]     = 1'b1;
                        cw[CW_OP]         = is_op(cap_opcode, OP_SUB);
                    end
                end
                default: begin
                    cw = '0;
                end
            endcase
        end
    end

    assign pc_inc     = cw[CW_PC_INC];
    assign pc_out     = cw[CW_PC_OUT];
    assign mar_load   = cw[CW_MAR_LOAD];
    assign ram_out    = cw[CW_RAM_OUT];
    assign ir_load    = cw[CW_IR_LOAD];
    assign ir_out     = cw[CW_IR_OUT];
    assign a_load     = cw[CW_A_LOAD];
    assign a_out      = cw[CW_A_OUT];
    assign b_load     = cw[CW_B_LOAD];
    assign op         = cw[CW_OP];
    assign alu_out_en = cw[CW_ALU_OUT_EN];
    assign out_load   = cw[CW_OUT_LOAD];

    assign halted  = (mode_q == MODE_HALT);
    assign t_state = rst ? T1 : ring;

endmodule : sap1_controller

// File: tb/tb_sap1_controller.sv
// -----------------------------------------------------------------------------
// tb_sap1_controller
// Scoreboard bench for sap1_controller. The driver applies one cycle of
// inputs at a time, asks a step-counting reference model what the controller
// must show during that cycle and queues it; an independent monitor pops and
// compares on every falling edge.
// -----------------------------------------------------------------------------
module tb_sap1_controller;

    logic       clk;
    logic       rst;
    logic [3:0] opcode;
    logic       pc_inc, pc_out, mar_load, ram_out, ir_load, ir_out;
    logic       a_load, a_out, b_load, op, alu_out_en, out_load;
    logic       halted;
    logic [5:0] t_state;

    int checks = 0;
    int errors = 0;

    // Bench-local strobe ordering
    localparam logic [10:0] M_PC_INC   = 11'b00000000001;
    localparam logic [10:0] M_PC_OUT   = 11'b00000000010;
    localparam logic [10:0] M_MAR      = 11'b00000000100;
    localparam logic [10:0] M_RAM_OUT  = 11'b00000001000;
    localparam logic [10:0] M_IR_LOAD  = 11'b00000010000;
    localparam logic [10:0] M_IR_OUT   = 11'b00000100000;
    localparam logic [10:0] M_A_LOAD   = 11'b00001000000;
    localparam logic [10:0] M_A_OUT    = 11'b00010000000;
    localparam logic [10:0] M_B_LOAD   = 11'b00100000000;
    localparam logic [10:0] M_ALU_OUT  = 11'b01000000000;
    localparam logic [10:0] M_OUT_LOAD = 11'b10000000000;

    typedef struct {
        logic [10:0] strobes;
        logic        op;
        logic [5:0]  t;
        logic        halted;
        bit          chk_halted;
        int          id;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: position within the instruction, halt flag and
    // the opcode remembered from T4.
    bit         m_halted = 1'b0;
    int         m_step   = 0;
    logic [3:0] m_cap    = 4'h0;
    int         cyc_id   = 0;

    sap1_controller #(.OPW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .pc_inc     (pc_inc),
        .pc_out     (pc_out),
        .mar_load   (mar_load),
        .ram_out    (ram_out),
        .ir_load    (ir_load),
        .ir_out     (ir_out),
        .a_load     (a_load),
        .a_out      (a_out),
        .b_load     (b_load),
        .op         (op),
        .alu_out_en (alu_out_en),
        .out_load   (out_load),
        .halted     (halted),
        .t_state    (t_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [10:0] ref_strobes(input int step, input logic [3:0] code);
        logic is_alu;
        is_alu = (code == 4'h1) || (code == 4'h2);
        case (step)
            0: return M_PC_OUT | M_MAR;
            1: return M_PC_INC;
            2: return M_RAM_OUT | M_IR_LOAD;
            3: begin
                if (code == 4'h0 || is_alu) return M_IR_OUT | M_MAR;
                if (code == 4'hE)           return M_A_OUT | M_OUT_LOAD;
                return '0;
            end
            4: begin
                if (code == 4'h0) return M_RAM_OUT | M_A_LOAD;
                if (is_alu)       return M_RAM_OUT | M_B_LOAD;
                return '0;
            end
            5: return is_alu ? (M_ALU_OUT | M_A_LOAD) : 11'b0;
            default: return '0;
        endcase
    endfunction

    // Drive one cycle, queue what the DUT must show during it, then advance
    // the model across the coming clock edge.
    task automatic applyStimulus(input logic r, input logic [3:0] code);
        exp_t       e;
        logic [3:0] dec;
        @(posedge clk);
        #1;
        rst    = r;
        opcode = code;
        cyc_id++;
        e.id = cyc_id;
        if (r) begin
            e.strobes    = '0;
            e.op         = 1'b0;
            e.t          = 6'b000001;
            e.halted     = 1'b0;
            e.chk_halted = 1'b0;
            m_halted = 1'b0;
            m_step   = 0;
            m_cap    = 4'h0;
        end else if (m_halted) begin
            e.strobes    = '0;
            e.op         = 1'b0;
            e.t          = 6'b000000;
            e.halted     = 1'b1;
            e.chk_halted = 1'b1;
        end else begin
            dec          = (m_step == 3) ? code : m_cap;
            e.strobes    = ref_strobes(m_step, dec);
            e.op         = (dec == 4'h2) && (m_step == 4 || m_step == 5);
            e.t          = 6'(1 << m_step);
            e.halted     = 1'b0;
            e.chk_halted = 1'b1;
            if (m_step == 3) begin
                m_cap = code;
                if (code == 4'hF) m_halted = 1'b1;
            end
            m_step = (m_step + 1) % 6;
        end
        exp_q.push_back(e);
    endtask

    task automatic runInstr(input logic [3:0] code);
        for (int k = 0; k < 6; k++) applyStimulus(1'b0, code);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [10:0] act;
        int          drivers;
        act = {out_load, alu_out_en, b_load, a_out, a_load, ir_out,
               ir_load, ram_out, mar_load, pc_out, pc_inc};
        checks++;
        if (act !== e.strobes) begin
            errors++;
            $display("[TB] FAIL strobes cyc=%0d actual=%b required=%b", e.id, act, e.strobes);
        end
        checks++;
        if (op !== e.op) begin
            errors++;
            $display("[TB] FAIL op cyc=%0d actual=%b required=%b", e.id, op, e.op);
        end
        checks++;
        if (t_state !== e.t) begin
            errors++;
            $display("[TB] FAIL t_state cyc=%0d actual=%b required=%b", e.id, t_state, e.t);
        end
        if (e.chk_halted) begin
            checks++;
            if (halted !== e.halted) begin
                errors++;
                $display("[TB] FAIL halted cyc=%0d actual=%b required=%b", e.id, halted, e.halted);
            end
        end
        drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out_en);
        checks++;
        if (drivers > 1) begin
            errors++;
            $display("[TB] FAIL bus_drivers cyc=%0d actual=%0d required<=1", e.id, drivers);
        end
    endtask

    // Monitor: compare whatever the driver queued for the current cycle
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog actual=timeout required=completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        logic [3:0] pick;
        int         halt_wait;
        rst    = 1'b1;
        opcode = 4'h0;

        // Reset held two cycles, then directed instruction mix
        applyStimulus(1'b1, 4'h0);
        applyStimulus(1'b1, 4'h0);
        runInstr(4'h0);
        runInstr(4'h1);
        runInstr(4'h2);

        // ADD whose opcode flips to SUB from T5 onward
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'h1);
        applyStimulus(1'b0, 4'h2);
        applyStimulus(1'b0, 4'h2);

        runInstr(4'hE);
        runInstr(4'h5);

        // HLT, parked for a while, then reset back to T1
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'hF);
        for (int k = 0; k < 20; k++) applyStimulus(1'b0, 4'($urandom_range(0, 15)));
        applyStimulus(1'b1, 4'h0);

        // Reset in T5 of an ADD, then a clean ADD
        for (int k = 0; k < 4; k++) applyStimulus(1'b0, 4'h1);
        applyStimulus(1'b1, 4'h1);
        runInstr(4'h1);

        // Randomised run: opcode is random outside T4, planned in T4
        halt_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            if (m_halted) begin
                halt_wait++;
                if (halt_wait > int'($urandom_range(3, 12))) begin
                    halt_wait = 0;
                    applyStimulus(1'b1, 4'($urandom_range(0, 15)));
                end else begin
                    applyStimulus(1'b0, 4'($urandom_range(0, 15)));
                end
            end else if ($urandom_range(0, 79) == 0) begin
                applyStimulus(1'b1, 4'($urandom_range(0, 15)));
            end else if (m_step == 3) begin
                case ($urandom_range(0, 9))
                    0: pick = 4'h0;
                    1: pick = 4'h1;
                    2: pick = 4'h2;
                    3: pick = 4'hE;
                    4: pick = 4'hF;
                    5: pick = 4'h1;
                    6: pick = 4'h2;
                    default: pick = 4'($urandom_range(0, 15));
                endcase
                applyStimulus(1'b0, pick);
            end else begin
                applyStimulus(1'b0, 4'($urandom_range(0, 15)));
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sap1_controller

// File: doc/sap1_controller.md
# sap1_controller

Controller-sequencer for the SAP-1 datapath: the initiator side of the ALU/register interface. It steps a six-state T-cycle ring, decodes the 4-bit opcode from the instruction register, and drives every load/enable strobe plus the ALU `op` select (0 = add, 1 = subtract). The ALU result `reg_A ± reg_B` is gated onto the bus only when this block asserts `alu_out_en`.

## Interface
Parameters:
- `OPW`, default 4: opcode width (upper nibble of IR).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  OPW  IR upper nibble; valid from T4 onward.
- `pc_inc`  out  1  Cp: program counter increment.
- `pc_out`  out  1  Ep: PC drives bus.
- `mar_load`  out  1  Lm: MAR loads from bus.
- `ram_out`  out  1  CE: RAM drives bus.
- `ir_load`  out  1  Li: IR loads from bus.
- `ir_out`  out  1  Ei: IR lower nibble drives bus.
- `a_load`  out  1  La: accumulator loads.
- `a_out`  out  1  Ea: accumulator drives bus.
- `b_load`  out  1  Lb: B register loads.
- `op`  out  1  Su: ALU select, 0 add, 1 subtract.
- `alu_out_en`  out  1  Eu: ALU result drives bus.
- `out_load`  out  1  Lo: output register loads.
- `halted`  out  1  high once HLT executes.
- `t_state`  out  6  one-hot T1..T6 (bit0 = T1); all-zero when halted.

## Operation
- Opcodes: LDA 0000, ADD 0001, SUB 0010, OUT 1110, HLT 1111; all others are NOP.
- Fetch, all instructions: T1: pc_out, mar_load. T2: pc_inc. T3: ram_out, ir_load.
- LDA: T4 ir_out, mar_load. T5 ram_out, a_load. T6 none.
- ADD: T4 ir_out, mar_load. T5 ram_out, b_load. T6 alu_out_en, a_load, op=0.
- SUB: as ADD, with op=1 in T5 and T6 (ALU output settled before the T6 strobe).
- OUT: T4 a_out, out_load. T5, T6 none.
- NOP: T4–T6 none.
- HLT: at T4, all strobes 0. On the T4 edge, enter HALT: `halted`=1, `t_state`=0, all strobes 0. HALT is left only by `rst`.
- Opcode is decoded live in T4 and captured into an internal register on the T4→T5 edge. T5/T6 decode uses the captured value, so opcode changes after T4 have no effect.
- Outputs are Moore-decoded from state and captured opcode. No strobe depends combinationally on `opcode` except in T4.

## Timing
- Reset values: state T1, `halted`=0, captured opcode 0000. While `rst`=1, every strobe and `op` are forced to 0 and `t_state`=000001.
- First cycle after `rst` deasserts is T1 with pc_out and mar_load high.
- Ring: T1→T2→…→T6→T1, one state per clock. An instruction takes 6 cycles, except HLT, which is in HALT 4 cycles after its T1.
- Reset mid-instruction (any T state or HALT): the next edge returns to T1 and the partial instruction is discarded. Strobes are 0 during the reset cycle.
- At most one bus driver (pc_out, ram_out, ir_out, a_out, alu_out_en) is asserted in any cycle. The bench checks this invariant every cycle.
- `op` changes only on state edges; it never glitches within a cycle.

## Structure
- `sap1_pkg` holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - T-state one-hot constants
  - control-word bit-index constants, shared with the datapath and the ALU bench
- Sub-module `ring_counter`: 6-bit one-hot shifter with synchronous reset to 000001 and a `hold` input that zeroes it for HALT.
- The decode is a single combinational block in `sap1_controller`.

## Test plan
- Reset: rst=1 for 2 cycles, then 0 → cycle 1 `t_state`=000001, pc_out=mar_load=1, all other strobes 0; cycle 2 pc_inc only.
- LDA: opcode=0000 → T4 ir_out+mar_load; T5 ram_out+a_load; T6 all 0; next cycle T1.
- ADD then SUB: opcode=0001 → T5 b_load, T6 alu_out_en+a_load with op=0. Next instruction opcode=0010 → op=1 in T5 and T6.
- Opcode change: opcode switched 0001→0010 during T5 → T6 still op=0 (captured opcode).
- OUT then HLT: opcode=1110 → T4 a_out+out_load. Next instruction opcode=1111 → after T4, halted=1 and t_state=0, held for 20 cycles; rst then returns to T1 with halted=0.
- Mid-instruction reset: rst pulsed in T5 of an ADD → no a_load in the following cycle; next cycle is T1. A NOP opcode 0101 yields all-zero strobes in T4–T6.
